// File: rtl/inv_round.sv
// inv_round: one decryption round on a 128-bit block, one stage per clock.
// Stage order: AddRoundKey -> InvMixColumns -> InvShiftRows -> InvSubBytes.
// Optional feature macro: INV_ROUND_FINAL_EN adds the final_round input,
// which skips InvMixColumns to undo the last encryption round.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a block; in_ready high once out of reset
// ADDKEY   | st ^= latched round key
// INVMIX   | InvMixColumns on every column (skipped for a final round)
// INVSHIFT | row r rotates right by r
// INVSUB   | inverse S-box on every byte, result loaded into roundout
// DONE     | out_valid high, roundout held until out_ready
module inv_round #(
  parameter int NB     = 4,
  parameter int BYTE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB*4*BYTE_W-1:0] roundin,
  input  logic [NB*4*BYTE_W-1:0] key,
`ifdef INV_ROUND_FINAL_EN
  input  logic                   final_round,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB*4*BYTE_W-1:0] roundout
);

  // Byte i of the block is element i, so byte 0 lands on the MSBs.
  typedef logic [0:4*NB-1][BYTE_W-1:0] blk_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDKEY   = 3'd1,
    INVMIX   = 3'd2,
    INVSHIFT = 3'd3,
    INVSUB   = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the InvMixColumns coefficients {0e,0b,0d,09}.
  function automatic logic [7:0] mul_coef(input logic [7:0] a, input logic [1:0] sel);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      2'd0:    return x8 ^ x4 ^ x2;
      2'd1:    return x8 ^ x2 ^ a;
      2'd2:    return x8 ^ x4 ^ a;
      default: return x8 ^ a;
    endcase
  endfunction

  function automatic blk_t inv_mix(input blk_t s);
    blk_t o;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = '0;
        for (int j = 0; j < 4; j++) begin
          o[4*c+r] = o[4*c+r] ^ mul_coef(s[4*c+j], 2'((j + 4 - r) % 4));
        end
      end
    end
    return o;
  endfunction

  function automatic blk_t inv_shift(input blk_t s);
    blk_t o;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = s[4*((c + NB - r) % NB) + r];
      end
    end
    return o;
  endfunction

  function automatic blk_t inv_sub(input blk_t s);
    blk_t o;
    for (int i = 0; i < 4*NB; i++) begin
      o[i] = INV_SBOX[s[i]];
    end
    return o;
  endfunction

  state_t                   state_q, state_d;
  blk_t                     st_q, st_d;
  blk_t                     key_q, key_d;
  logic [NB*4*BYTE_W-1:0]   roundout_q, roundout_d;
  logic                     live_q, live_d;
  logic                     skip_mix;

`ifdef INV_ROUND_FINAL_EN
  logic fin_q, fin_d;
  assign skip_mix = fin_q;
`else
  assign skip_mix = 1'b0;
`endif

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign roundout  = roundout_q;

  // Next-state and datapath: exactly one transformation per state.
  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    key_d      = key_q;
    roundout_d = roundout_q;
    live_d     = 1'b1;
`ifdef INV_ROUND_FINAL_EN
    fin_d      = fin_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          st_d    = roundin;
          key_d   = key;
`ifdef INV_ROUND_FINAL_EN
          fin_d   = final_round;
`endif
          state_d = ADDKEY;
        end
      end
      ADDKEY: begin
        st_d    = st_q ^ key_q;
        state_d = skip_mix ? INVSHIFT : INVMIX;
      end
      INVMIX: begin
        st_d    = inv_mix(st_q);
        state_d = INVSHIFT;
      end
      INVSHIFT: begin
        st_d    = inv_shift(st_q);
        state_d = INVSUB;
      end
      INVSUB: begin
        roundout_d = inv_sub(st_q);
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      st_q       <= '0;
      key_q      <= '0;
      roundout_q <= '0;
      live_q     <= 1'b0;
`ifdef INV_ROUND_FINAL_EN
      fin_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      key_q      <= key_d;
      roundout_q <= roundout_d;
      live_q     <= live_d;
`ifdef INV_ROUND_FINAL_EN
      fin_q      <= fin_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_round.sv
// Testbench for inv_round: directed vectors feed a scoreboard queue, a
// monitor pops and checks each block as out_valid rises and at handshake.
module tb_inv_round;

  typedef logic [0:15][7:0] blk_t;

  typedef struct {
    logic [127:0] din;
    logic [127:0] k;
    logic [127:0] exp;
    int           acc;
    bit           fin;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] roundin;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] roundout;
`ifdef INV_ROUND_FINAL_EN
  logic         final_round;
`endif

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  force_low = 1'b0;
  sb_t q[$];
  sb_t cur;
  bit  have_cur = 1'b0;
  bit  prev_v = 1'b0;

  logic [7:0] sb[256];
  logic [7:0] isb[256];

  inv_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .roundin    (roundin),
    .key        (key),
`ifdef INV_ROUND_FINAL_EN
    .final_round(final_round),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .roundout   (roundout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream readiness changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: field inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] inv_model(input logic [127:0] d, input logic [127:0] k, input bit fin);
    blk_t s, t;
    s = d ^ k;
    if (!fin) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = gm(8'h0e, s[4*c+r]) ^ gm(8'h0b, s[4*c+(r+1)%4])
                   ^ gm(8'h0d, s[4*c+(r+2)%4]) ^ gm(8'h09, s[4*c+(r+3)%4]);
      s = t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = s[4*((c+4-r)%4)+r];
    for (int i = 0; i < 16; i++) s[i] = isb[t[i]];
    return s;
  endfunction

  function automatic logic [127:0] enc_model(input logic [127:0] d, input logic [127:0] k, input bit fin);
    blk_t s, t;
    s = d;
    for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[4*c+r] = t[4*((c+r)%4)+r];
    if (!fin) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = gm(8'h02, s[4*c+r]) ^ gm(8'h03, s[4*c+(r+1)%4])
                   ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
      s = t;
    end
    return s ^ k;
  endfunction

  // Monitor: check value, latency and round trip on out_valid rise, and
  // value stability plus in_ready low at the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=no output", roundout);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("roundout", roundout, cur.exp);
          chk("latency", 128'(cyc - cur.acc), cur.fin ? 128'd3 : 128'd4);
          chk("roundtrip", enc_model(roundout, cur.k, cur.fin), cur.din);
        end
      end
      if (out_valid && out_ready && have_cur) begin
        chk("hold_value", roundout, cur.exp);
        chk("busy_in_ready", 128'(in_ready), 128'd0);
        have_cur = 1'b0;
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input bit fin,
                      input logic [127:0] exp, input bit push);
    sb_t e;
    int  n;
    @(negedge clk);
    in_valid = 1'b1;
    roundin  = d;
    key      = k;
`ifdef INV_ROUND_FINAL_EN
    final_round = fin;
`endif
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready 0 required=in_ready 1");
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.din = d; e.k = k; e.exp = exp; e.acc = cyc + 1; e.fin = fin;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    roundin  = {$urandom, $urandom, $urandom, $urandom};
    key      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(in_ready && q.size() == 0 && !have_cur) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=queue %0d required=queue 0", q.size());
    end
  endtask

  task automatic send_model(input logic [127:0] d, input logic [127:0] k, input bit fin);
    send(d, k, fin, inv_model(d, k, fin), 1'b1);
  endtask

  initial begin
    logic [127:0] d, k;
    int n;
    rst      = 1'b0;
    in_valid = 1'b0;
    roundin  = '0;
    key      = '0;
    out_ready = 1'b0;
`ifdef INV_ROUND_FINAL_EN
    final_round = 1'b0;
`endif
    build_tables();

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_roundout", roundout, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready), 128'd1);

    send('0, '0, 1'b0, {16{8'h52}}, 1'b1);
    send({16{8'h63}}, '0, 1'b0, '0, 1'b1);
    drain();

    // Downstream stalls: output must hold with in_ready low.
    force_low = 1'b1;
    send({16{8'hff}}, {16{8'hff}}, 1'b0, {16{8'h52}}, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", 128'(out_valid), 128'd1);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
      chk("stall_roundout", roundout, {16{8'h52}});
      @(negedge clk);
    end
    force_low = 1'b0;
    drain();

    send_model(128'h000102030405060708090a0b0c0d0e0f, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
    send_model(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0);
    send_model(128'h80000000000000000000000000000001, '0, 1'b0);
    drain();

    // Reset while the block sits in INVMIX: no output may follow.
    send(128'h0123456789abcdeffedcba9876543210, 128'h1, 1'b0, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_roundout", roundout, 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    chk("abort_in_ready_hold", 128'(in_ready), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", 128'(in_ready), 128'd1);
    repeat (10) @(negedge clk);

`ifdef INV_ROUND_FINAL_EN
    send({8'h01, 120'h0}, '0, 1'b1, {8'h09, {15{8'h52}}}, 1'b1);
`endif

    for (int i = 0; i < 24; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef INV_ROUND_FINAL_EN
      send_model(d, k, bit'($urandom_range(0, 1)));
`else
      send_model(d, k, 1'b0);
`endif
    end
    drain();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
